md_issue_ctrl: RTL and testbench
================================

Name: md_issue_ctrl

Overview:
- Execute-stage initiator for the pipeline's multiply/divide unit (HI/LO unit).
- Decodes the MD-class instruction in E and drives the unit's `start`/`sel`/`D1`/`D2`.
- Tracks the unit's latency with its own countdown and raises the D-stage stall when the unit is busy.
- Generates the `remthi`/`remtlo` undo pulses when an MTHI/MTLO that already wrote is cancelled in M.

Parameters:
- MUL_LAT, 5, cycles from the start edge until HI/LO are written for MULT/MULTU.
- DIV_LAT, 10, cycles from the start edge until HI/LO are written for DIV/DIVU.
- CNT_W, 4, width of the pending countdown; must hold max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- IntReq  in  1  interrupt/exception taken this cycle; blocks issue and aborts a first-cycle operation.
- e_valid  in  1  E-stage instruction valid (not a bubble).
- e_op  in  3  E-stage MD op: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
- e_is_md  in  1  E-stage instruction is MD-class; e_op is ignored when 0.
- e_rs  in  32  forwarded rs value in E.
- e_rt  in  32  forwarded rt value in E.
- d_md_use  in  1  D-stage instruction is MD-class (any of the 8 ops).
- m_cancel  in  1  the instruction now in M is being cancelled.
- md_busy  in  1  Busy from the multiply/divide unit.
- md_start  out  1  start to the unit.
- md_sel  out  3  sel to the unit.
- md_d1  out  32  D1 to the unit; equals e_rs.
- md_d2  out  32  D2 to the unit; equals e_rt.
- hilo_rd  out  2  E-stage read-mux select: 0 none, 1 HI (MFHI), 2 LO (MFLO).
- remthi  out  1  restore HI from its shadow copy.
- remtlo  out  1  restore LO from its shadow copy.
- stall_d  out  1  freeze the D stage and insert a bubble into E.
- pend_cnt  out  CNT_W  cycles remaining for the in-flight operation; 0 means idle.
- ovlp_err  out  1  sticky flag: an issue was attempted while an operation was in flight.

Behaviour:
- Combinational terms:
  - issue_ok = e_valid & e_is_md & ~IntReq & ~reset.
  - inflight = md_busy | (pend_cnt != 0).
- md_start:
  - Asserted when issue_ok & e_op < 4 & ~inflight.
  - Single cycle: E advances or is bubbled by stall_d on the following cycle.
- md_sel:
  - Equals e_op when issue_ok & e_op in 0..5.
  - Equals 7 otherwise (the unit ignores 6 and 7).
  - MTHI/MTLO (sel 4/5) issue even while inflight; the unit accepts them in parallel.
- hilo_rd: 1 if issue_ok & e_op == 6; 2 if issue_ok & e_op == 7; else 0.
- md_d1 / md_d2: direct pass-through of e_rs / e_rt in all cycles.
- pend_cnt (registered):
  - On md_start: load MUL_LAT for ops 0/1, DIV_LAT for ops 2/3.
  - Else if pend_cnt == LAT_loaded & IntReq: clear to 0. This mirrors the unit aborting in its first state. The loaded latency is held in a 1-bit is_div register.
  - Else if pend_cnt != 0: decrement by 1.
  - IntReq at later counts does not abort.
- stall_d:
  - = d_md_use & (md_start | inflight).
  - Covers the cycle of the start edge, before md_busy rises.
- Undo tracking, registered flags m_mthi / m_mtlo:
  - Set at the edge where issue_ok & e_op == 4 / 5.
  - Otherwise cleared every cycle; each flag represents exactly the instruction now in M.
  - remthi = m_mthi & m_cancel.
  - remtlo = m_mtlo & m_cancel.
  - Both are combinational one-cycle pulses; the unit restores HI/LO at the next edge.
- ovlp_err:
  - Set at an edge where issue_ok & e_op < 4 & inflight. The issue itself is suppressed.
  - Held until reset. Indicates a broken stall chain.
- Reset:
  - Synchronous; takes effect at the next edge, including mid-operation.
  - Clears pend_cnt, is_div, m_mthi, m_mtlo and ovlp_err.
  - While reset is high: md_start = 0, md_sel = 7, hilo_rd = 0, remthi = remtlo = 0.
- Simultaneous events:
  - IntReq together with a valid MULT in E: no start; pend_cnt is unchanged.
  - m_cancel together with a new MTHI in E: the remthi pulse is still produced, and m_mthi reloads from the new issue only if IntReq = 0.

Test Plan:
1. MULT in E with rs = 7, rt = -3 and idle unit -> md_start = 1, md_sel = 0; pend_cnt reads 5, 4, 3, 2, 1, 0 on the following edges; a D-stage MFLO stalls for 6 cycles.
2. DIVU with rs = 100, rt = 7 -> md_sel = 3, pend_cnt loads 10; a second DIV forced into E at count 4 -> ovlp_err = 1, md_start stays 0.
3. MULT issued, IntReq = 1 on the next cycle (pend_cnt = 5) -> pend_cnt = 0 after that edge; stall_d drops once md_busy falls.
4. MTHI in E with rs = 0xDEADBEEF, then m_cancel = 1 the next cycle -> remthi = 1 for exactly one cycle, remtlo = 0.
5. MTLO in E during a pending DIV at count 6 -> md_sel = 5, md_start = 0, pend_cnt keeps decrementing, ovlp_err = 0.
6. Reset asserted at pend_cnt = 3 with ovlp_err = 1 -> after the edge pend_cnt = 0, ovlp_err = 0, md_start = 0, md_sel = 7.

Source files
------------

// File: rtl/md_issue_ctrl.sv
// Execute-stage issue control for the HI/LO multiply/divide unit: decodes the MD op in E,
// tracks unit latency with a local countdown, drives the D-stage stall and MTHI/MTLO undo pulses.
module md_issue_ctrl #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10,
  parameter int unsigned CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IntReq,
  input  logic             e_valid,
  input  logic [2:0]       e_op,
  input  logic             e_is_md,
  input  logic [31:0]      e_rs,
  input  logic [31:0]      e_rt,
  input  logic             d_md_use,
  input  logic             m_cancel,
  input  logic             md_busy,
  output logic             md_start,
  output logic [2:0]       md_sel,
  output logic [31:0]      md_d1,
  output logic [31:0]      md_d2,
  output logic [1:0]       hilo_rd,
  output logic             remthi,
  output logic             remtlo,
  output logic             stall_d,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             ovlp_err
);

  localparam logic [2:0]       SEL_NONE = 3'd7;
  localparam logic [2:0]       OP_MTHI  = 3'd4;
  localparam logic [2:0]       OP_MTLO  = 3'd5;
  localparam logic [2:0]       OP_MFHI  = 3'd6;
  localparam logic [2:0]       OP_MFLO  = 3'd7;
  localparam logic [CNT_W-1:0] LAT_MUL  = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] LAT_DIV  = CNT_W'(DIV_LAT);

  logic [CNT_W-1:0] r_pend_cnt;
  logic             r_is_div;
  logic             r_m_mthi;
  logic             r_m_mtlo;
  logic             r_ovlp_err;

  logic             w_issue_ok;
  logic             w_inflight;
  logic             w_is_arith;
  logic             w_start;
  logic [CNT_W-1:0] w_lat_ld;
  logic [CNT_W-1:0] w_lat_cur;

  // Issue qualification and in-flight detection
  always_comb begin
    w_issue_ok = e_valid & e_is_md & ~IntReq & ~reset;
    w_inflight = md_busy | (r_pend_cnt != '0);
    w_is_arith = ~e_op[2];
    w_start    = w_issue_ok & w_is_arith & ~w_inflight;
    w_lat_ld   = e_op[1] ? LAT_DIV : LAT_MUL;
    w_lat_cur  = r_is_div ? LAT_DIV : LAT_MUL;
  end

  // Countdown, undo flags and sticky overlap error
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_cnt <= '0;
      r_is_div   <= 1'b0;
      r_m_mthi   <= 1'b0;
      r_m_mtlo   <= 1'b0;
      r_ovlp_err <= 1'b0;
    end else begin
      if (w_start) begin
        r_pend_cnt <= w_lat_ld;
        r_is_div   <= e_op[1];
      end else if ((r_pend_cnt == w_lat_cur) && IntReq) begin
        // Unit drops an operation interrupted in its first busy cycle
        r_pend_cnt <= '0;
      end else if (r_pend_cnt != '0) begin
        r_pend_cnt <= r_pend_cnt - CNT_W'(1);
      end
      r_m_mthi <= w_issue_ok & (e_op == OP_MTHI);
      r_m_mtlo <= w_issue_ok & (e_op == OP_MTLO);
      if (w_issue_ok & w_is_arith & w_inflight) begin
        r_ovlp_err <= 1'b1;
      end
    end
  end

  // Unit-facing and pipeline-facing outputs
  always_comb begin
    md_start = w_start;
    md_sel   = SEL_NONE;
    hilo_rd  = 2'd0;
    if (w_issue_ok && (e_op <= OP_MTLO)) begin
      md_sel = e_op;
    end
    if (w_issue_ok && (e_op == OP_MFHI)) begin
      hilo_rd = 2'd1;
    end else if (w_issue_ok && (e_op == OP_MFLO)) begin
      hilo_rd = 2'd2;
    end
    md_d1    = e_rs;
    md_d2    = e_rt;
    remthi   = r_m_mthi & m_cancel & ~reset;
    remtlo   = r_m_mtlo & m_cancel & ~reset;
    stall_d  = d_md_use & (w_start | w_inflight);
    pend_cnt = r_pend_cnt;
    ovlp_err = r_ovlp_err;
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: stimulus pushes hand-computed expectations into a
// scoreboard queue; a monitor samples DUT outputs on the falling edge and compares.
module tb_md_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        IntReq = 1'b0;
  logic        e_valid = 1'b0;
  logic [2:0]  e_op = 3'd0;
  logic        e_is_md = 1'b0;
  logic [31:0] e_rs = 32'd0;
  logic [31:0] e_rt = 32'd0;
  logic        d_md_use = 1'b0;
  logic        m_cancel = 1'b0;
  logic        md_busy = 1'b0;
  logic        md_start;
  logic [2:0]  md_sel;
  logic [31:0] md_d1;
  logic [31:0] md_d2;
  logic [1:0]  hilo_rd;
  logic        remthi;
  logic        remtlo;
  logic        stall_d;
  logic [3:0]  pend_cnt;
  logic        ovlp_err;

  md_issue_ctrl #(.MUL_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .IntReq(IntReq), .e_valid(e_valid), .e_op(e_op),
    .e_is_md(e_is_md), .e_rs(e_rs), .e_rt(e_rt), .d_md_use(d_md_use),
    .m_cancel(m_cancel), .md_busy(md_busy), .md_start(md_start), .md_sel(md_sel),
    .md_d1(md_d1), .md_d2(md_d2), .hilo_rd(hilo_rd), .remthi(remthi), .remtlo(remtlo),
    .stall_d(stall_d), .pend_cnt(pend_cnt), .ovlp_err(ovlp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        st;
    logic [2:0]  sel;
    logic [1:0]  hl;
    logic        rh;
    logic        rl;
    logic        sd;
    logic [3:0]  pc;
    logic        ov;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  function automatic void cmp(string nm, string fld, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
    end
  endfunction

  // Monitor: one expectation record per cycle, sampled mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp(e.nm, "md_start", 32'(md_start), 32'(e.st));
        cmp(e.nm, "md_sel",   32'(md_sel),   32'(e.sel));
        cmp(e.nm, "hilo_rd",  32'(hilo_rd),  32'(e.hl));
        cmp(e.nm, "remthi",   32'(remthi),   32'(e.rh));
        cmp(e.nm, "remtlo",   32'(remtlo),   32'(e.rl));
        cmp(e.nm, "stall_d",  32'(stall_d),  32'(e.sd));
        cmp(e.nm, "pend_cnt", 32'(pend_cnt), 32'(e.pc));
        cmp(e.nm, "ovlp_err", 32'(ovlp_err), 32'(e.ov));
        cmp(e.nm, "md_d1",    md_d1,         e.d1);
        cmp(e.nm, "md_d2",    md_d2,         e.d2);
      end
    end
  end

  task automatic step(input string nm, input logic rst, input logic irq, input logic ev,
                      input logic md, input logic [2:0] op, input logic [31:0] rs,
                      input logic [31:0] rt, input logic du, input logic mc, input logic bz,
                      input logic x_st, input logic [2:0] x_sel, input logic [1:0] x_hl,
                      input logic x_rh, input logic x_rl, input logic x_sd,
                      input logic [3:0] x_pc, input logic x_ov);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; IntReq = irq; e_valid = ev; e_is_md = md; e_op = op;
    e_rs = rs; e_rt = rt; d_md_use = du; m_cancel = mc; md_busy = bz;
    e.nm = nm; e.st = x_st; e.sel = x_sel; e.hl = x_hl; e.rh = x_rh; e.rl = x_rl;
    e.sd = x_sd; e.pc = x_pc; e.ov = x_ov; e.d1 = rs; e.d2 = rt;
    q.push_back(e);
  endtask

  task automatic idle(input string nm, input logic du, input logic [3:0] x_pc,
                      input logic x_sd, input logic x_ov);
    step(nm, 0,0,0,0,3'd0,32'd0,32'd0, du,0,0,  0,3'd7,2'd0,0,0,x_sd,x_pc,x_ov);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    //    name         rst irq ev md op   rs            rt            du mc bz  st sel  hl  rh rl sd pc     ov
    step("rst_hold",    1,  0,  1, 1, 3'd0, 32'd1,        32'd2,        1, 0, 0,  0, 3'd7,2'd0,0, 0, 0, 4'd0,  0);
    // MULT 7 * -3, with an MFLO waiting in D
    step("t1_mult",     0,  0,  1, 1, 3'd0, 32'd7,        32'hFFFFFFFD, 1, 0, 0,  1, 3'd0,2'd0,0, 0, 1, 4'd0,  0);
    idle("t1_c5", 1, 4'd5, 1, 0);
    idle("t1_c4", 1, 4'd4, 1, 0);
    idle("t1_c3", 1, 4'd3, 1, 0);
    idle("t1_c2", 1, 4'd2, 1, 0);
    idle("t1_c1", 1, 4'd1, 1, 0);
    idle("t1_c0", 1, 4'd0, 0, 0);
    // DIVU 100 / 7, MTLO in parallel, then a forced overlapping DIV
    step("t2_divu",     0,  0,  1, 1, 3'd3, 32'd100,      32'd7,        0, 0, 0,  1, 3'd3,2'd0,0, 0, 0, 4'd0,  0);
    idle("t2_c10", 0, 4'd10, 0, 0);
    idle("t2_c9",  0, 4'd9,  0, 0);
    idle("t2_c8",  0, 4'd8,  0, 0);
    idle("t2_c7",  1, 4'd7,  1, 0);
    step("t5_mtlo",     0,  0,  1, 1, 3'd5, 32'h00001234, 32'd0,        0, 0, 0,  0, 3'd5,2'd0,0, 0, 0, 4'd6,  0);
    step("t5_cancel",   0,  0,  0, 0, 3'd0, 32'd0,        32'd0,        0, 1, 0,  0, 3'd7,2'd0,0, 1, 0, 4'd5,  0);
    step("t2_ovlp",     0,  0,  1, 1, 3'd2, 32'd9,        32'd3,        0, 0, 0,  0, 3'd2,2'd0,0, 0, 0, 4'd4,  0);
    // Reset mid-operation with the error flag set
    step("t6_rst",      1,  0,  1, 1, 3'd0, 32'd1,        32'd1,        0, 0, 0,  0, 3'd7,2'd0,0, 0, 0, 4'd3,  1);
    idle("t6_after", 0, 4'd0, 0, 0);
    // MULTU aborted by IntReq in its first pending cycle
    step("t3_multu",    0,  0,  1, 1, 3'd1, 32'd5,        32'd6,        0, 0, 0,  1, 3'd1,2'd0,0, 0, 0, 4'd0,  0);
    step("t3_irq",      0,  1,  0, 0, 3'd0, 32'd0,        32'd0,        1, 0, 1,  0, 3'd7,2'd0,0, 0, 1, 4'd5,  0);
    step("t3_busy",     0,  0,  0, 0, 3'd0, 32'd0,        32'd0,        1, 0, 1,  0, 3'd7,2'd0,0, 0, 1, 4'd0,  0);
    idle("t3_free", 1, 4'd0, 0, 0);
    // IntReq later in the operation does not abort
    step("late_mult",   0,  0,  1, 1, 3'd0, 32'd2,        32'd2,        0, 0, 0,  1, 3'd0,2'd0,0, 0, 0, 4'd0,  0);
    idle("late_c5", 0, 4'd5, 0, 0);
    step("late_irq",    0,  1,  0, 0, 3'd0, 32'd0,        32'd0,        0, 0, 0,  0, 3'd7,2'd0,0, 0, 0, 4'd4,  0);
    idle("late_c3", 0, 4'd3, 0, 0);
    idle("late_c2", 0, 4'd2, 0, 0);
    idle("late_c1", 0, 4'd1, 0, 0);
    // IntReq blocks a MULT issue; count stays idle
    step("irq_mult",    0,  1,  1, 1, 3'd0, 32'd3,        32'd4,        0, 0, 0,  0, 3'd7,2'd0,0, 0, 0, 4'd0,  0);
    idle("irq_after", 0, 4'd0, 0, 0);
    // MTHI undo pulse, then cancel colliding with new MTHI issues
    step("t4_mthi",     0,  0,  1, 1, 3'd4, 32'hDEADBEEF, 32'd0,        0, 0, 0,  0, 3'd4,2'd0,0, 0, 0, 4'd0,  0);
    step("t4_cancel",   0,  0,  0, 0, 3'd0, 32'd0,        32'd0,        0, 1, 0,  0, 3'd7,2'd0,1, 0, 0, 4'd0,  0);
    step("t4_once",     0,  0,  0, 0, 3'd0, 32'd0,        32'd0,        0, 1, 0,  0, 3'd7,2'd0,0, 0, 0, 4'd0,  0);
    step("sim_mthi",    0,  0,  1, 1, 3'd4, 32'h11,       32'd0,        0, 0, 0,  0, 3'd4,2'd0,0, 0, 0, 4'd0,  0);
    step("sim_reload",  0,  0,  1, 1, 3'd4, 32'h22,       32'd0,        0, 1, 0,  0, 3'd4,2'd0,1, 0, 0, 4'd0,  0);
    step("sim_irq",     0,  1,  1, 1, 3'd4, 32'h33,       32'd0,        0, 1, 0,  0, 3'd7,2'd0,1, 0, 0, 4'd0,  0);
    step("sim_cleared", 0,  0,  0, 0, 3'd0, 32'd0,        32'd0,        0, 1, 0,  0, 3'd7,2'd0,0, 0, 0, 4'd0,  0);
    // HI/LO read select and non-MD qualification
    step("mfhi",        0,  0,  1, 1, 3'd6, 32'd0,        32'd0,        0, 0, 0,  0, 3'd7,2'd1,0, 0, 0, 4'd0,  0);
    step("mflo",        0,  0,  1, 1, 3'd7, 32'd0,        32'd0,        0, 0, 0,  0, 3'd7,2'd2,0, 0, 0, 4'd0,  0);
    step("not_md",      0,  0,  1, 0, 3'd0, 32'h55,       32'h66,       1, 0, 0,  0, 3'd7,2'd0,0, 0, 0, 4'd0,  0);
    step("bubble",      0,  0,  0, 1, 3'd2, 32'h77,       32'h88,       0, 0, 0,  0, 3'd7,2'd0,0, 0, 0, 4'd0,  0);
    idle("end_idle", 0, 4'd0, 0, 0);
    stim_done = 1'b1;
  end

  // Drain the scoreboard with a bounded wait, then report
  initial begin
    int budget;
    budget = 0;
    wait (stim_done);
    while (q.size() > 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
